// File: rtl/debug_event_packer_if.sv
// debug_event_packer_if: event capture inputs and serializer handshake of the debug event packer
interface debug_event_packer_if;
    logic        ev_valid;
    logic [7:0]  ev_tag;
    logic [15:0] ev_payload;
    logic        sender_state;
    logic        data_valid;
    logic [39:0] data;
    modport master (output ev_valid, ev_tag, ev_payload, sender_state, input data_valid, data);
    modport slave (input ev_valid, ev_tag, ev_payload, sender_state, output data_valid, data);
endinterface

// File: rtl/debug_event_packer.sv
// debug_event_packer: timestamps and packs debug events, buffers them and issues them to the serializer
module debug_event_packer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024,
    parameter int GUARD   = 4
) (
    input  logic                     in_clk,
    input  logic                     reset,
    debug_event_packer_if.slave      bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               drop_count,
    output logic [7:0]               timeout_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GUARD + 1);
    localparam logic [AW:0]   FULL  = (AW + 1)'(DEPTH);
    localparam logic [WW-1:0] TLAST = WW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GLOAD = GW'(GUARD);
    typedef enum logic [1:0] {IDLE, PULSE, WAIT_BUSY, WAIT_IDLE} state_t;
    state_t        state;
    logic [39:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [15:0]   ts;
    logic          ss_m, ss_s;
    logic [WW-1:0] wait_cnt;
    logic [GW-1:0] guard_cnt;
    logic          pop, push;
    assign pop  = state == IDLE && fifo_count != '0 && !ss_s && guard_cnt == '0;
    assign push = bus.ev_valid && (fifo_count != FULL || pop);
    always_ff @(posedge in_clk)
        if (push) mem[wr_ptr] <= {bus.ev_tag, ts, bus.ev_payload};
    always_ff @(posedge in_clk) begin
        if (reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            ts             <= '0;
            ss_m           <= 1'b0;
            ss_s           <= 1'b0;
            wait_cnt       <= '0;
            guard_cnt      <= '0;
            fifo_count     <= '0;
            drop_count     <= '0;
            timeout_count  <= '0;
            bus.data_valid <= 1'b0;
            bus.data       <= '0;
        end else begin
            ts             <= ts + 16'd1;
            ss_m           <= bus.sender_state;
            ss_s           <= ss_m;
            bus.data_valid <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (bus.ev_valid && !push && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            if (push && !pop) fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
            case (state)
                IDLE: begin
                    if (guard_cnt != '0) guard_cnt <= guard_cnt - 1'b1;
                    if (pop) begin
                        bus.data       <= mem[rd_ptr];
                        rd_ptr         <= rd_ptr + 1'b1;
                        bus.data_valid <= 1'b1;
                        state          <= PULSE;
                    end
                end
                PULSE: begin
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // busy acknowledgement wins over a timeout landing in the same cycle
                    if (ss_s) state <= WAIT_IDLE;
                    else if (wait_cnt == TLAST) begin
                        if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
                        bus.data_valid <= 1'b1;
                        state          <= PULSE;
                    end else wait_cnt <= wait_cnt + 1'b1;
                end
                default: if (!ss_s) begin
                    guard_cnt <= GLOAD;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
